// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Command/status bundle between the keyboard/mouse command logic (master)
//   and the PS/2 host transmitter (slave).
//   wr_ps2       : push din into the transmit FIFO           (master -> slave)
//   din          : command byte                               (master -> slave)
//   fifo_full    : FIFO holds FIFO_DEPTH entries              (slave -> master)
//   tx_idle      : transmitter idle and FIFO empty            (slave -> master)
//   tx_done_tick : one-cycle pulse, byte sent and ACKed       (slave -> master)
//   tx_err_tick  : one-cycle pulse, transaction failed        (slave -> master)
//   err_code     : 01 timeout, 10 NACK                        (slave -> master)
//   ovf_tick     : one-cycle pulse, push while full, dropped  (slave -> master)
interface ps2_host_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       fifo_full;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;
    logic [1:0] err_code;
    logic       ovf_tick;

    modport master (
        output wr_ps2, din,
        input  fifo_full, tx_idle, tx_done_tick, tx_err_tick, err_code, ovf_tick
    );

    modport slave (
        input  wr_ps2, din,
        output fifo_full, tx_idle, tx_done_tick, tx_err_tick, err_code, ovf_tick
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter with a command FIFO, clock-rate
//   independent RTS timing, ACK checking, a transaction watchdog and
//   error reporting. Pins are open drain: only ever driven 0 or released.
//   Ports:
//     clk, reset : system clock, asynchronous active-high reset
//     bus        : ps2_host_tx_if.slave (command push and status)
//     ps2c, ps2d : shared PS/2 clock and data pins
//   Optional feature macro: PS2_HOST_TX_RETRY_EN
//     defined   -> a failed byte is resent from RTS up to 2 times before
//                  the error is reported
//     undefined -> the first failure is reported immediately
module ps2_host_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int RTS_US     = 100,
    parameter int TIMEOUT_US = 15000,
    parameter int FIFO_DEPTH = 4,
    parameter int FILTER_LEN = 8
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus,
    inout  wire          ps2c,
    inout  wire          ps2d
);
    localparam int RTS_CYC = CLK_HZ / 1_000_000 * RTS_US;
    localparam int TO_CYC  = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int RC_W    = (RTS_CYC > 1) ? $clog2(RTS_CYC) : 1;
    localparam int WD_W    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK, REL} state_t;

    state_t            state_reg, state_next;
    logic [RC_W-1:0]   rc_reg, rc_next;
    logic [WD_W-1:0]   wd_reg, wd_next;
    logic [3:0]        n_reg, n_next;
    logic [8:0]        b_reg, b_next;
    logic [1:0]        err_code_reg;

    logic [FILTER_LEN-1:0] filt_reg;
    logic              f_ps2c_reg, f_ps2c_next, fall_edge;
    logic              ps2d_meta, ps2d_sync;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW:0]       w_ptr, r_ptr;
    logic              fifo_empty, fifo_full, push, pop;
    logic [7:0]        fifo_dout;

    logic              wd_active, timeout, nack, fail, give_up;
    logic [1:0]        fail_code;
    logic              clk_drive, dat_drive, tx_done, tx_err;

`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]        retry_reg, retry_next;
    logic [7:0]        byte_reg, byte_next;
`endif

    // Glitch filter on ps2c plus a two-flop synchroniser on ps2d.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_reg   <= '0;
            f_ps2c_reg <= 1'b0;
            ps2d_meta  <= 1'b1;
            ps2d_sync  <= 1'b1;
        end else begin
            filt_reg   <= {ps2c, filt_reg[FILTER_LEN-1:1]};
            f_ps2c_reg <= f_ps2c_next;
            ps2d_meta  <= ps2d;
            ps2d_sync  <= ps2d_meta;
        end
    end

    // Filtered clock only changes once every sample agrees.
    assign f_ps2c_next = (&filt_reg) ? 1'b1 : ((~|filt_reg) ? 1'b0 : f_ps2c_reg);
    assign fall_edge   = f_ps2c_reg & ~f_ps2c_next;

    // FIFO pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (w_ptr == r_ptr);
    assign fifo_full  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
    assign pop        = (state_reg == IDLE) && !fifo_empty;
    assign push       = bus.wr_ps2 && (!fifo_full || pop);
    assign fifo_dout  = mem[r_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (push) w_ptr <= w_ptr + 1'b1;
            if (pop)  r_ptr <= r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[w_ptr[AW-1:0]] <= bus.din;
    end

    // Failure detection; the watchdog wins over a coincident clock edge.
    assign wd_active = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP) ||
                       (state_reg == ACK)   || (state_reg == REL);
    assign timeout   = wd_active && (wd_reg == WD_W'(TO_CYC - 1));
    assign nack      = (state_reg == ACK) && fall_edge && ps2d_sync;
    assign fail      = timeout || nack;
    assign fail_code = timeout ? 2'b01 : 2'b10;
`ifdef PS2_HOST_TX_RETRY_EN
    assign give_up   = fail && (retry_reg == 2'd2);
`else
    assign give_up   = fail;
`endif

    // State register and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            rc_reg       <= '0;
            wd_reg       <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            err_code_reg <= 2'b00;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_reg    <= 2'd0;
            byte_reg     <= 8'h00;
`endif
        end else begin
            state_reg <= state_next;
            rc_reg    <= rc_next;
            wd_reg    <= wd_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            if (give_up) err_code_reg <= fail_code;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_reg <= retry_next;
            byte_reg  <= byte_next;
`endif
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_next = state_reg;
        rc_next    = rc_reg;
        wd_next    = wd_reg;
        n_next     = n_reg;
        b_next     = b_reg;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_next = retry_reg;
        byte_next  = byte_reg;
`endif
        if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
            if (retry_reg != 2'd2) begin
                retry_next = retry_reg + 2'd1;
                rc_next    = RC_W'(RTS_CYC - 1);
                b_next     = {~^byte_reg, byte_reg};
                state_next = RTS;
            end else begin
                state_next = IDLE;
            end
`else
            state_next = IDLE;
`endif
        end else begin
            if (wd_active) wd_next = wd_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        b_next     = {~^fifo_dout, fifo_dout};
                        rc_next    = RC_W'(RTS_CYC - 1);
                        state_next = RTS;
`ifdef PS2_HOST_TX_RETRY_EN
                        retry_next = 2'd0;
                        byte_next  = fifo_dout;
`endif
                    end
                end
                RTS: begin
                    wd_next = '0;
                    if (rc_reg == '0) state_next = START;
                    else              rc_next    = rc_reg - 1'b1;
                end
                START: begin
                    if (fall_edge) begin
                        n_next     = 4'd8;
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (fall_edge) begin
                        b_next = {1'b0, b_reg[8:1]};
                        if (n_reg == 4'd0) state_next = STOP;
                        else               n_next     = n_reg - 1'b1;
                    end
                end
                STOP: begin
                    if (fall_edge) state_next = ACK;
                end
                ACK: begin
                    if (fall_edge) state_next = REL;
                end
                REL: begin
                    if (ps2d_sync && f_ps2c_reg) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Pin enables and status pulses; all decoded from the current state so
    // that an asynchronous reset releases the pins immediately.
    always_comb begin
        clk_drive = (state_reg == RTS);
        dat_drive = (state_reg == START) || ((state_reg == DATA) && !b_reg[0]);
        tx_done   = (state_reg == REL) && ps2d_sync && f_ps2c_reg && !timeout;
        tx_err    = give_up;
    end

    assign ps2c = clk_drive ? 1'b0 : 1'bz;
    assign ps2d = dat_drive ? 1'b0 : 1'bz;

    assign bus.fifo_full    = fifo_full;
    assign bus.tx_idle      = (state_reg == IDLE) && fifo_empty;
    assign bus.tx_done_tick = tx_done;
    assign bus.tx_err_tick  = tx_err;
    assign bus.err_code     = err_code_reg;
    assign bus.ovf_tick     = bus.wr_ps2 && fifo_full && !pop;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Directed self-checking bench for ps2_host_tx with a behavioural PS/2
//   device model (10 kHz clock at a 1 MHz system clock) on pulled-up pins.
module tb_ps2_host_tx;
    logic clk;
    logic reset;
    wire  ps2c;
    wire  ps2d;
    logic dev_clk_low;
    logic dev_dat_low;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int low_cnt = 0;
    int last_low_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_gap = 0;
    logic [1:0] post_err_pins = 2'b00;
    logic err_prev = 1'b0;

    ps2_host_tx_if bus_if ();

    ps2_host_tx #(
        .CLK_HZ     (1_000_000),
        .RTS_US     (100),
        .TIMEOUT_US (2000),
        .FIFO_DEPTH (4),
        .FILTER_LEN (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .ps2c  (ps2c),
        .ps2d  (ps2d)
    );

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2d = dev_dat_low ? 1'b0 : 1'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor sampled on the falling system clock edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (err_prev) post_err_pins = {ps2c, ps2d};
        err_prev = bus_if.tx_err_tick;
        if (bus_if.tx_done_tick === 1'b1) done_cnt = done_cnt + 1;
        if (bus_if.tx_err_tick === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_gap = cyc - last_low_cyc;
        end
        if (ps2c === 1'b0 && !dev_clk_low) begin
            low_cnt      = low_cnt + 1;
            last_low_cyc = cyc;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ovf);
        bus_if.wr_ps2 = 1'b1;
        bus_if.din    = b;
        #1;
        ovf = bus_if.ovf_tick;
        @(posedge clk);
        #1;
        bus_if.wr_ps2 = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_rts(output logic ok);
        int t;
        ok = 1'b0;
        t  = 0;
        while (ps2c !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (ps2c === 1'b0) begin
            t = 0;
            while (ps2c !== 1'b1 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            ok = (ps2c === 1'b1);
        end
        check_output("rts_seen", {31'd0, ok}, 32'd1);
    endtask

    // Device side of one frame: 11 clocked bits sampled while ps2c is high,
    // then a 12th clock carrying the ACK bit (ack_bit=0 acknowledges).
    task automatic dev_frame(input logic ack_bit, output logic [10:0] bits);
        logic ok;
        bits = '0;
        wait_rts(ok);
        if (ok) begin
            repeat (20) @(negedge clk);
            for (int i = 0; i < 11; i++) begin
                repeat (40) @(negedge clk);
                bits[i] = ps2d;
                repeat (10) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (50) @(negedge clk);
                dev_clk_low = 1'b0;
            end
            repeat (10) @(negedge clk);
            dev_dat_low = ~ack_bit;
            repeat (40) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (50) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_events(input int done_target, input int err_target, input int budget);
        int t;
        t = 0;
        while ((done_cnt < done_target || err_cnt < err_target) && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        logic [10:0] bits;
        logic        ovf;
        logic        ok;
        int          done_base, err_base, low_base;
        logic [7:0]  t2_bytes [3];
        logic [10:0] t2_frames [3];
        int          nack_frames;

        t2_bytes[0] = 8'hFF;  t2_frames[0] = 11'h7FE;
        t2_bytes[1] = 8'hF4;  t2_frames[1] = 11'h5E8;
        t2_bytes[2] = 8'h00;  t2_frames[2] = 11'h600;

        reset         = 1'b1;
        dev_clk_low   = 1'b0;
        dev_dat_low   = 1'b0;
        bus_if.wr_ps2 = 1'b0;
        bus_if.din    = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check_output("rst_fifo_full", {31'd0, bus_if.fifo_full}, 32'd0);
        check_output("rst_tx_idle",   {31'd0, bus_if.tx_idle}, 32'd1);
        check_output("rst_done_tick", {31'd0, bus_if.tx_done_tick}, 32'd0);
        check_output("rst_err_tick",  {31'd0, bus_if.tx_err_tick}, 32'd0);
        check_output("rst_ovf_tick",  {31'd0, bus_if.ovf_tick}, 32'd0);
        check_output("rst_err_code",  {30'd0, bus_if.err_code}, 32'd0);
        check_output("rst_ps2c",      {31'd0, ps2c}, 32'd1);
        check_output("rst_ps2d",      {31'd0, ps2d}, 32'd1);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Single byte 0xED, ACKed.
        $display("[TB] single byte 0xED");
        done_base = done_cnt;
        err_base  = err_cnt;
        low_base  = low_cnt;
        write_byte(8'hED, ovf);
        dev_frame(1'b0, bits);
        wait_events(done_base + 1, 0, 500);
        check_output("t1_rts_low_cycles", low_cnt - low_base, 32'd100);
        check_output("t1_frame", {21'd0, bits}, 32'h7DA);
        check_output("t1_done_count", done_cnt - done_base, 32'd1);
        check_output("t1_err_count", err_cnt - err_base, 32'd0);
        check_output("t1_err_code", {30'd0, bus_if.err_code}, 32'd0);

        // Three back-to-back bytes.
        $display("[TB] three queued bytes");
        done_base = done_cnt;
        write_byte(t2_bytes[0], ovf);
        write_byte(t2_bytes[1], ovf);
        write_byte(t2_bytes[2], ovf);
        for (int i = 0; i < 3; i++) begin
            dev_frame(1'b0, bits);
            check_output($sformatf("t2_frame%0d", i), {21'd0, bits}, {21'd0, t2_frames[i]});
        end
        wait_events(done_base + 3, 0, 500);
        repeat (5) @(negedge clk);
        check_output("t2_done_count", done_cnt - done_base, 32'd3);
        check_output("t2_tx_idle", {31'd0, bus_if.tx_idle}, 32'd1);

        // FIFO fill and overflow while the device stays silent.
        $display("[TB] fifo fill and overflow");
        err_base = err_cnt;
        for (int i = 0; i < 5; i++) begin
            write_byte(8'h10 + 8'(i), ovf);
            check_output($sformatf("t3_ovf_write%0d", i), {31'd0, ovf}, 32'd0);
        end
        check_output("t3_fifo_full", {31'd0, bus_if.fifo_full}, 32'd1);
        write_byte(8'h99, ovf);
        check_output("t3_ovf_sixth", {31'd0, ovf}, 32'd1);

        // Watchdog timeout on the first popped byte.
        $display("[TB] watchdog timeout");
        wait_events(0, err_base + 1, 8000);
        repeat (3) @(negedge clk);
        check_output("t4_err_count", err_cnt - err_base, 32'd1);
        check_output("t4_err_gap", err_gap, 32'd2000);
        check_output("t4_err_code", {30'd0, bus_if.err_code}, 32'd1);
        check_output("t4_pins_released", {30'd0, post_err_pins}, 32'd3);
        apply_reset();

        // NACK from the device.
        $display("[TB] device NACK");
        done_base = done_cnt;
        err_base  = err_cnt;
`ifdef PS2_HOST_TX_RETRY_EN
        nack_frames = 3;
`else
        nack_frames = 1;
`endif
        write_byte(8'hA5, ovf);
        for (int i = 0; i < nack_frames; i++) begin
            dev_frame(1'b1, bits);
            check_output($sformatf("t5_frame%0d", i), {21'd0, bits}, 32'h74A);
        end
        wait_events(0, err_base + 1, 500);
        repeat (3) @(negedge clk);
        check_output("t5_err_count", err_cnt - err_base, 32'd1);
        check_output("t5_err_code", {30'd0, bus_if.err_code}, 32'd2);
        check_output("t5_done_count", done_cnt - done_base, 32'd0);

        // Reset in the middle of DATA.
        $display("[TB] reset during data");
        write_byte(8'h00, ovf);
        write_byte(8'h55, ovf);
        wait_rts(ok);
        repeat (20) @(negedge clk);
        repeat (50) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (50) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        check_output("t6_data_bit0_driven", {31'd0, ps2d}, 32'd0);
        reset = 1'b1;
        #1;
        check_output("t6_ps2d_released", {31'd0, ps2d}, 32'd1);
        check_output("t6_ps2c_released", {31'd0, ps2c}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        low_base = low_cnt;
        repeat (150) @(negedge clk);
        check_output("t6_tx_idle", {31'd0, bus_if.tx_idle}, 32'd1);
        check_output("t6_fifo_full", {31'd0, bus_if.fifo_full}, 32'd0);
        check_output("t6_err_code", {30'd0, bus_if.err_code}, 32'd0);
        check_output("t6_no_new_rts", low_cnt - low_base, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
